// File: rtl/value_uart_tx.sv
// -----------------------------------------------------------------------------
// value_uart_tx
//
// UART transmitter that sits after the button-driven value storage block. It
// takes an 8-bit value with a one-cycle trigger and sends it as an 8N1 frame
// (start 0, data LSB first, stop 1) on tx. A one-byte holding register lets the
// producer offer a second byte while a frame is still going out. A one-cycle
// completion pulse is returned for every byte sent.
//
// Optional feature: define VALUE_UART_TX_PARITY_EN to put an even-parity bit
// between the last data bit and the stop bit. The frame then takes
// 11*CLKS_PER_BIT cycles instead of 10*CLKS_PER_BIT.
//
// Parameters
//   CLKS_PER_BIT      clock cycles per UART bit (>= 2)
//
// Ports
//   clk               system clock, all logic on posedge
//   rst_n             asynchronous active-low reset
//   in_value[7:0]     byte to send, sampled only while in_trigger=1
//   in_trigger        one-cycle pulse that offers in_value
//   out_ready_trigger one-cycle pulse after each byte's stop bit completes
//   tx                UART line, idle high
//   busy              frame in progress or holding register occupied
//   overflow          sticky: an offered byte was dropped (cleared by reset)
// -----------------------------------------------------------------------------
module value_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_value,
    input  logic       in_trigger,
    output logic       out_ready_trigger,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("value_uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    localparam int              CW        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef VALUE_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Registered state
    state_t          r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_hold_data;
    logic            r_hold_full;
    logic            r_done;
    logic            r_busy;
    logic            r_overflow;
    logic            r_tx;
`ifdef VALUE_UART_TX_PARITY_EN
    logic            r_parity;
    logic            w_parity_next;
`endif

    // Next-state values
    state_t          w_state_next;
    logic [CW-1:0]   w_baud_next;
    logic [2:0]      w_bit_next;
    logic [7:0]      w_shift_next;
    logic [7:0]      w_hold_data_next;
    logic            w_hold_full_next;
    logic            w_done_next;
    logic            w_busy_next;
    logic            w_overflow_next;
    logic            w_tx_next;
    logic            w_baud_wrap;

    always_comb begin
        w_state_next     = r_state;
        w_baud_next      = r_baud_cnt;
        w_bit_next       = r_bit_idx;
        w_shift_next     = r_shift;
        w_hold_data_next = r_hold_data;
        w_hold_full_next = r_hold_full;
        w_overflow_next  = r_overflow;
        w_done_next      = 1'b0;
        w_tx_next        = 1'b1;
        w_busy_next      = 1'b0;
`ifdef VALUE_UART_TX_PARITY_EN
        w_parity_next    = r_parity;
`endif
        w_baud_wrap      = (r_baud_cnt == BAUD_LAST);

        // Baud counter runs in every non-idle state and restarts on each bit
        if (r_state == IDLE) begin
            w_baud_next = '0;
        end else if (w_baud_wrap) begin
            w_baud_next = '0;
        end else begin
            w_baud_next = r_baud_cnt + 1'b1;
        end

        // Frame sequencing
        case (r_state)
            IDLE: begin
                w_state_next = IDLE;
            end
            START: begin
                if (w_baud_wrap) begin
                    w_state_next = DATA;
                    w_bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (w_baud_wrap) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef VALUE_UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef VALUE_UART_TX_PARITY_EN
            PARITY: begin
                if (w_baud_wrap) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_baud_wrap) begin
                    w_done_next = 1'b1;
                    if (r_hold_full) begin
                        // Drain the holding register straight into a new
                        // frame so there is no idle gap between bytes.
                        w_state_next     = START;
                        w_shift_next     = r_hold_data;
                        w_hold_full_next = 1'b0;
`ifdef VALUE_UART_TX_PARITY_EN
                        w_parity_next    = ^r_hold_data;
`endif
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Acceptance is judged against the post-sequencing view: a frame
        // ending this cycle with an empty holding register behaves as IDLE,
        // and a holding register being drained this cycle counts as free.
        if (in_trigger) begin
            if (w_state_next == IDLE) begin
                w_state_next = START;
                w_shift_next = in_value;
                w_baud_next  = '0;
`ifdef VALUE_UART_TX_PARITY_EN
                w_parity_next = ^in_value;
`endif
            end else if (!w_hold_full_next) begin
                w_hold_data_next = in_value;
                w_hold_full_next = 1'b1;
            end else begin
                w_overflow_next = 1'b1;
            end
        end

        w_busy_next = (w_state_next != IDLE) || w_hold_full_next;

        // tx is registered, so it is derived from the state being entered
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef VALUE_UART_TX_PARITY_EN
            PARITY:  w_tx_next = w_parity_next;
`endif
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_hold_data <= 8'd0;
            r_hold_full <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
            r_tx        <= 1'b1;
`ifdef VALUE_UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_baud_cnt  <= w_baud_next;
            r_bit_idx   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_hold_data <= w_hold_data_next;
            r_hold_full <= w_hold_full_next;
            r_done      <= w_done_next;
            r_busy      <= w_busy_next;
            r_overflow  <= w_overflow_next;
            r_tx        <= w_tx_next;
`ifdef VALUE_UART_TX_PARITY_EN
            r_parity    <= w_parity_next;
`endif
        end
    end

    assign out_ready_trigger = r_done;
    assign tx                = r_tx;
    assign busy              = r_busy;
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_value_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_value_uart_tx
//
// Scoreboard bench for value_uart_tx (CLKS_PER_BIT=4). Stimulus pushes the
// expected byte and expected completion cycle into queues; a negedge monitor
// decodes the tx line as a UART receiver, watches the done pulse, busy and
// overflow, and compares against those queues. The reference model works on a
// frame timeline: each accepted byte owns a window of FRAME cycles, a byte is
// held if one frame is pending, and dropped if two are pending.
// -----------------------------------------------------------------------------
module tb_value_uart_tx;

    localparam int CPB = 4;
`ifdef VALUE_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_value = 8'd0;
    logic       in_trigger = 1'b0;
    logic       out_ready_trigger;
    logic       tx;
    logic       busy;
    logic       overflow;

    value_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_value          (in_value),
        .in_trigger        (in_trigger),
        .out_ready_trigger (out_ready_trigger),
        .tx                (tx),
        .busy              (busy),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model / scoreboard state
    typedef struct { int acc; int done; } span_t;
    span_t      live[$];      // acceptance..completion window of each byte
    int         m_pend[$];    // completion cycles of bytes still owned by the model
    logic [7:0] sb_bytes[$];  // bytes expected on the line, in order
    int         sb_done[$];   // cycles at which done pulses are expected
    int         ovf_edge = -1;

    task automatic model_reset();
        live.delete();
        m_pend.delete();
        sb_bytes.delete();
        sb_done.delete();
        ovf_edge = -1;
    endtask

    // c = index of the rising edge that samples the trigger
    task automatic model_offer(input int c, input logic [7:0] b);
        int d;
        while (m_pend.size() > 0 && m_pend[0] <= c) void'(m_pend.pop_front());
        if (m_pend.size() == 0) begin
            d = c + FRAME;
        end else if (m_pend.size() == 1) begin
            d = m_pend[0] + FRAME;
        end else begin
            if (ovf_edge < 0) ovf_edge = c;
            $display("offer 0x%02h at edge %0d: dropped", b, c);
            return;
        end
        m_pend.push_back(d);
        sb_bytes.push_back(b);
        sb_done.push_back(d);
        live.push_back('{c, d});
        $display("offer 0x%02h at edge %0d: done expected at %0d", b, c, d);
    endtask

    task automatic drive(input logic trig, input logic [7:0] v);
        @(negedge clk);
        in_trigger = trig;
        in_value   = v;
        if (trig) model_offer(cyc + 1, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
    endtask

    task automatic apply_reset(input int hold_cycles);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        in_trigger = 1'b0;
        model_reset();
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_done", int'(out_ready_trigger), 0);
        repeat (hold_cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: done pulses, busy, overflow and a UART line decoder
    int         rx_active = 0;
    int         rx_start  = 0;
    logic [7:0] rx_byte   = 8'd0;
    logic       rx_par    = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 0;
        end else begin
            if (out_ready_trigger) begin
                if (sb_done.size() == 0) begin
                    check("done_spurious", 1, 0);
                end else begin
                    check("done_time", cyc, sb_done[0]);
                    $display("done pulse at %0d (expected %0d)", cyc, sb_done[0]);
                    void'(sb_done.pop_front());
                end
            end else if (sb_done.size() > 0 && sb_done[0] <= cyc) begin
                check("done_missing", cyc, sb_done[0]);
                void'(sb_done.pop_front());
            end

            begin
                int exp_busy;
                exp_busy = 0;
                foreach (live[i]) if (live[i].acc <= cyc && cyc < live[i].done) exp_busy = 1;
                check("busy", int'(busy), exp_busy);
                while (live.size() > 0 && live[0].done <= cyc) void'(live.pop_front());
            end

            check("overflow", int'(overflow), (ovf_edge >= 0 && cyc >= ovf_edge) ? 1 : 0);

            if (rx_active == 0 && tx == 1'b0) begin
                rx_active = 1;
                rx_start  = cyc;
                rx_byte   = 8'd0;
            end
            if (rx_active != 0) begin
                int off;
                int j;
                off = cyc - rx_start;
                j   = off / CPB;
                if (off % CPB == CPB / 2) begin
                    if (j == 0) begin
                        check("rx_start_bit", int'(tx), 0);
                    end else if (j <= 8) begin
                        rx_byte[j-1] = tx;
                    end else if (j < NBITS - 1) begin
                        rx_par = tx;
                    end else begin
                        check("rx_stop_bit", int'(tx), 1);
                        rx_active = 0;
                        if (sb_bytes.size() == 0) begin
                            check("rx_spurious", int'(rx_byte), -1);
                        end else begin
                            $display("rx byte 0x%02h (expected 0x%02h)", rx_byte, sb_bytes[0]);
                            check("rx_byte", int'(rx_byte), int'(sb_bytes[0]));
`ifdef VALUE_UART_TX_PARITY_EN
                            check("rx_parity", int'(rx_par), $countones(sb_bytes[0]) % 2);
`endif
                            void'(sb_bytes.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset and quiet line
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(50);
        check("idle_tx", int'(tx), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_overflow", int'(overflow), 0);

        // Single byte
        drive(1'b1, 8'hA5);
        idle(FRAME + 10);

        // Back-to-back: second byte ten cycles after the first
        drive(1'b1, 8'h01);
        idle(9);
        drive(1'b1, 8'h80);
        idle(2 * FRAME + 10);
        check("b2b_overflow", int'(overflow), 0);

        // Overflow: three consecutive offers, third is dropped
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b1, 8'h33);
        idle(2 * FRAME + 10);
        check("ovf_sticky", int'(overflow), 1);

        // Reset in the middle of DATA bit 3 of 0xFF, then a clean frame
        drive(1'b1, 8'hFF);
        idle(17);
        apply_reset(2);
        idle(5);
        drive(1'b1, 8'h0F);
        idle(FRAME + 10);

        // Randomized traffic, including offers at frame boundaries
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) drive(1'b1, 8'($urandom));
            else drive(1'b0, 8'($urandom));
        end
        idle(3 * FRAME + 10);

        check("sb_done_empty", sb_done.size(), 0);
        check("sb_bytes_empty", sb_bytes.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
